pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges four hazard sources into one consistent set of per-stage write-enable and bubble controls:
  - data-memory wait
  - multi-cycle mul/div occupancy of EX
  - taken-branch redirect
  - load-use dependency
- Keeps registered mul/div tracking, a mul/div watchdog and saturating stall/flush performance counters.
- Sits beside the pipeline registers and drives their enables.

Parameters:
- CNT_W, 32, width of stall_count and flush_count.
- MD_TIMEOUT, 64, consecutive mul/div stall cycles before md_timeout asserts.
- TO_W, 7, width of the mul/div stall counter; must hold MD_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_muldiv_start  in  1  EX holds a mul/div instruction.
- muldiv_done  in  1  mul/div result valid this cycle; the unit holds the result until EX advances.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID is loaded with a NOP.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  ID/EX is loaded with a NOP.
- ex_mem_write  out  1  EX/MEM register enable.
- ex_mem_bubble  out  1  EX/MEM is loaded with a NOP.
- mem_wb_bubble  out  1  MEM/WB is loaded with a NOP.
- md_busy  out  1  registered: mul/div in flight.
- md_timeout  out  1  sticky watchdog flag.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  cycles with if_id_flush=1.

Behaviour:
- Combinational terms:
  - mem_stall = dmem_req && !dmem_ready.
  - md_stall = (ex_muldiv_start || md_busy) && !muldiv_done && !md_done_pend.
  - load_use = ex_memread && ex_rd!=0 && ((id_rs1_used && ex_rd==id_rs1) || (id_rs2_used && ex_rd==id_rs2)).
  - x0 never creates a hazard.
- Defaults: all *_write=1, all flush/bubble=0. The first matching case below applies; there is no mixing.
- Case 1, mem_stall:
  - pc_write, if_id_write, id_ex_write and ex_mem_write = 0; mem_wb_bubble=1.
  - A branch in EX is ignored this cycle. It is held and re-evaluated next cycle.
- Case 2, md_stall:
  - pc_write, if_id_write and id_ex_write = 0; ex_mem_bubble=1.
  - MEM and WB keep draining.
- Case 3, ex_branch_taken:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Takes priority over load_use, because the dependent instruction is flushed.
- Case 4, load_use:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, for exactly one cycle.
  - The condition clears when the load moves to MEM.
- While rst=1: all *_write=0, all bubbles/flush=1.
- Registered state (all cleared asynchronously by rst):
  - md_busy: set when ex_muldiv_start && !md_busy && !muldiv_done; cleared on muldiv_done.
  - md_done_pend:
    - Set when muldiv_done && mem_stall.
    - Cleared on the first cycle with !mem_stall, which is when EX advances.
    - Lets EX advance without waiting for a second done.
  - md_cnt (TO_W bits): +1 each md_stall cycle, saturating; cleared when md_stall=0.
  - md_timeout: set when md_cnt reaches MD_TIMEOUT-1 while md_stall is still 1; cleared only by rst.
  - stall_count: +1 when pc_write=0 and rst=0; saturates at all-ones.
  - flush_count: +1 when if_id_flush=1; saturates at all-ones.
- Simultaneous muldiv_done and mem_stall:
  - Mem freeze wins.
  - The md_done_pend path guarantees the mul/div does not re-stall after memory completes.
- Reset mid-stall: all registered state returns to 0. Any outstanding mul/div result is discarded by the pipeline flush.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the x0 constant REG_ZERO=5'd0
  - a stall-cause enum: CAUSE_NONE, CAUSE_MEM, CAUSE_MD, CAUSE_BR, CAUSE_LU
  - the CNT_W default
- Priority selection is computed once as a cause value and decoded into outputs.
- One sub-module: sat_counter (parameter W, inputs inc and clr), instantiated for stall_count, flush_count and md_cnt.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for 1 cycle.
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; stall_count=1.
- x0 dependency: ex_memread=1, ex_rd=0, id_rs1=0, id_rs1_used=1.
  - Response: no stall; all writes=1.
- Branch with load-use: ex_branch_taken=1 together with the load-use case above.
  - Response: if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_count unchanged.
- Mul/div stall: ex_muldiv_start=1, muldiv_done after 4 cycles.
  - Response: md_busy=1 from cycle 2; ex_mem_bubble=1 and pc_write=0 for 4 cycles; all writes=1 in the done cycle.
- Done under mem stall: mul/div in flight, dmem_req=1 with dmem_ready=0 for 3 cycles, muldiv_done pulses in the 2nd of those cycles.
  - Response: full freeze for 3 cycles, mem_wb_bubble=1.
  - Next cycle: no md_stall, all writes=1.
- Watchdog: ex_muldiv_start=1 with muldiv_done held 0 for 70 cycles.
  - Response: md_timeout=1 after cycle 64, remains 1 until rst.
  - Asserting rst mid-stall clears md_busy, md_timeout and both counters immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Architectural zero register: writes to it never create a dependency.
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Default width of the performance counters.
    localparam int         CNT_W_DEF = 32;

    // Winning hazard for the current cycle, in priority order.
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_MEM  = 3'd1,
        CAUSE_MD   = 3'd2,
        CAUSE_BR   = 3'd3,
        CAUSE_LU   = 3'd4
    } cause_e;

    // True when an ID source operand depends on a non-x0 destination.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic       used);
        return used && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, async active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    // Count up on inc, stick at all-ones, clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: picks one hazard cause per
// cycle and decodes it into the pipeline-register enables and bubble controls.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             ex_mem_bubble,
    output logic             mem_wb_bubble,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MD_TIMEOUT - 1);

    logic            mem_stall_s;
    logic            md_stall_s;
    logic            load_use_s;
    logic            md_done_pend_r;
    logic [TO_W-1:0] md_cnt_s;
    logic            stall_inc_s;
    cause_e          cause_s;

    assign mem_stall_s = dmem_req && !dmem_ready;
    assign md_stall_s  = (ex_muldiv_start || md_busy) && !muldiv_done && !md_done_pend_r;
    assign load_use_s  = ex_memread &&
                         (reg_match(ex_rd, id_rs1, id_rs1_used) ||
                          reg_match(ex_rd, id_rs2, id_rs2_used));
    assign stall_inc_s = !pc_write && !rst;

    // Pick the single highest-priority hazard for this cycle.
    always_comb begin
        cause_s = CAUSE_NONE;
        if (mem_stall_s) begin
            cause_s = CAUSE_MEM;
        end else if (md_stall_s) begin
            cause_s = CAUSE_MD;
        end else if (ex_branch_taken) begin
            cause_s = CAUSE_BR;
        end else if (load_use_s) begin
            cause_s = CAUSE_LU;
        end else begin
            cause_s = CAUSE_NONE;
        end
    end

    // Decode the cause into stage enables; reset forces every stage to a NOP.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else begin
            case (cause_s)
                CAUSE_MEM: begin
                    // Freeze everything up to EX/MEM; WB gets a bubble.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                end
                CAUSE_MD: begin
                    // Hold front end and EX; MEM/WB keep draining.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
                CAUSE_BR: begin
                    // Squash the two wrong-path instructions behind the branch.
                    pc_write      = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                end
                CAUSE_LU: begin
                    // Hold the consumer in ID for one cycle behind the load.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_bubble  = 1'b1;
                end
                CAUSE_NONE: begin
                    pc_write      = 1'b1;
                end
                default: begin
                    pc_write      = 1'b1;
                end
            endcase
        end
    end

    // Track an in-flight mul/div; a result already latched as pending must
    // not re-arm tracking for the instruction still sitting in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_busy <= 1'b0;
        end else if (muldiv_done) begin
            md_busy <= 1'b0;
        end else if (ex_muldiv_start && !md_busy && !md_done_pend_r) begin
            md_busy <= 1'b1;
        end else begin
            md_busy <= md_busy;
        end
    end

    // Remember a mul/div completion that arrived while memory froze EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_done_pend_r <= 1'b0;
        end else if (muldiv_done && mem_stall_s) begin
            md_done_pend_r <= 1'b1;
        end else if (!mem_stall_s) begin
            md_done_pend_r <= 1'b0;
        end else begin
            md_done_pend_r <= md_done_pend_r;
        end
    end

    // Sticky watchdog: mul/div has stalled EX for MD_TIMEOUT cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_timeout <= 1'b0;
        end else if (md_stall_s && (md_cnt_s >= TO_LIMIT)) begin
            md_timeout <= 1'b1;
        end else begin
            md_timeout <= md_timeout;
        end
    end

    sat_counter #(.W(TO_W)) u_md_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (md_stall_s),
        .clr   (!md_stall_s),
        .count (md_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .clr   (1'b0),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .clr   (1'b0),
        .count (flush_count)
    );

endmodule
